// File: rtl/mmio_pkg.sv
// Shared types and default memory map for the MMIO bus decoder.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int MAX_SLV = 16;

    localparam logic [31:0] MEM_BASE  = 32'h0000_0000;
    localparam logic [31:0] MEM_MASK  = 32'hFFFF_E000;
    localparam logic [31:0] TC_BASE   = 32'hFFFF_0000;
    localparam logic [31:0] TC_MASK   = 32'hFFFF_F000;
    localparam logic [31:0] UART_BASE = 32'hFFFF_1000;
    localparam logic [31:0] UART_MASK = 32'hFFFF_F000;
    localparam logic [31:0] GPIO_BASE = 32'hFFFF_2000;
    localparam logic [31:0] GPIO_MASK = 32'hFFFF_F000;

    // Slave 0 sits in the low 32 bits.
    localparam logic [127:0] DEF_SLV_BASE = {GPIO_BASE, UART_BASE, TC_BASE, MEM_BASE};
    localparam logic [127:0] DEF_SLV_MASK = {GPIO_MASK, UART_MASK, TC_MASK, MEM_MASK};

endpackage

// File: rtl/mmio_bus_decoder_if.sv
// Core-side request/response and per-slave select/ready signals of the MMIO decoder.
interface mmio_bus_decoder_if #(
    parameter int NUM_SLV = 4
);
    logic                    req;
    logic                    we;
    logic [31:0]             addr;
    logic [NUM_SLV-1:0]      slv_ready;
    logic [32*NUM_SLV-1:0]   slv_rdata;
    logic [NUM_SLV-1:0]      CS_N;
    logic                    slv_we;
    logic [31:0]             rdata;
    logic                    ack;
    logic                    err;
    logic                    busy;

    modport slave (
        input  req, we, addr, slv_ready, slv_rdata,
        output CS_N, slv_we, rdata, ack, err, busy
    );

    modport master (
        output req, we, addr, slv_ready, slv_rdata,
        input  CS_N, slv_we, rdata, ack, err, busy
    );
endinterface

// File: rtl/mmio_region_match.sv
// Combinational base/mask region compare with lowest-index priority.
module mmio_region_match #(
    parameter int                    NUM_SLV  = 4,
    parameter int                    IDX_W    = 2,
    parameter logic [32*NUM_SLV-1:0] SLV_BASE = '0,
    parameter logic [32*NUM_SLV-1:0] SLV_MASK = '0
) (
    input  logic [31:0]      addr_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);
    // Scan downwards so the last match written is the lowest index.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((addr_i & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/mmio_bus_decoder.sv
// Registered MMIO decoder/transaction controller: IDLE -> ACCESS -> RESP.
// Optional fault logging ports are built when MMIO_FAULT_LOG_EN is defined.
module mmio_bus_decoder
    import mmio_pkg::*;
#(
    parameter int                    NUM_SLV  = 4,
    parameter logic [32*NUM_SLV-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [32*NUM_SLV-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int                    TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    mmio_bus_decoder_if.slave   bus
`ifdef MMIO_FAULT_LOG_EN
    ,
    input  logic                fault_clr,
    output logic [31:0]         fault_addr,
    output logic                fault_is_to,
    output logic [7:0]          fault_cnt
`endif
);
    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e             state_q, state_d;
    logic [NUM_SLV-1:0] cs_n_q, cs_n_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               we_q, we_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               sel_rdy;
    logic               to_hit;

    mmio_region_match #(
        .NUM_SLV  (NUM_SLV),
        .IDX_W    (IDX_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_match (
        .addr_i (bus.addr),
        .hit_o  (hit),
        .idx_o  (hit_idx)
    );

    assign sel_rdy = bus.slv_ready[idx_q];

    if (TIMEOUT > 0) begin : g_to
        logic [CNT_W-1:0] cnt_q, cnt_d;
        assign cnt_d  = (state_q == ACCESS) ? cnt_q + CNT_W'(1) : '0;
        assign to_hit = (state_q == ACCESS) && (cnt_q == CNT_W'(TIMEOUT - 1));
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) cnt_q <= '0;
            else          cnt_q <= cnt_d;
        end
    end else begin : g_no_to
        assign to_hit = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req) state_d = hit ? ACCESS : RESP;
            ACCESS:  if (sel_rdy || to_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is checked before timeout so a late ready on the last cycle still acks.
    always_comb begin
        cs_n_d  = cs_n_q;
        idx_d   = idx_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (hit) begin
                        idx_d           = hit_idx;
                        we_d            = bus.we;
                        cs_n_d          = '1;
                        cs_n_d[hit_idx] = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (sel_rdy) begin
                    ack_d  = 1'b1;
                    cs_n_d = '1;
                    we_d   = 1'b0;
                    if (!we_q) rdata_d = bus.slv_rdata[32*idx_q +: 32];
                end else if (to_hit) begin
                    err_d  = 1'b1;
                    cs_n_d = '1;
                    we_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_n_q  <= '1;
            idx_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cs_n_q  <= cs_n_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.CS_N   = cs_n_q;
    assign bus.slv_we = we_q;
    assign bus.rdata  = rdata_q;
    assign bus.ack    = ack_q;
    assign bus.err    = err_q;
    assign bus.busy   = (state_q != IDLE);

`ifdef MMIO_FAULT_LOG_EN
    logic [31:0] addr_q, fault_addr_q;
    logic        fault_is_to_q;
    logic [7:0]  fault_cnt_q;

    // Timeouts report the address latched at decode, misses the live address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q        <= '0;
            fault_addr_q  <= '0;
            fault_is_to_q <= 1'b0;
            fault_cnt_q   <= '0;
        end else begin
            if (state_q == IDLE && bus.req && hit) addr_q <= bus.addr;
            if (err_d) begin
                fault_addr_q  <= (state_q == ACCESS) ? addr_q : bus.addr;
                fault_is_to_q <= (state_q == ACCESS);
                if (fault_clr)                 fault_cnt_q <= 8'd1;
                else if (fault_cnt_q != 8'hFF) fault_cnt_q <= fault_cnt_q + 8'd1;
            end else if (fault_clr) begin
                fault_addr_q  <= '0;
                fault_is_to_q <= 1'b0;
                fault_cnt_q   <= '0;
            end
        end
    end

    assign fault_addr  = fault_addr_q;
    assign fault_is_to = fault_is_to_q;
    assign fault_cnt   = fault_cnt_q;
`endif

endmodule

// File: doc/mmio_bus_decoder.md
# mmio_bus_decoder

Parametrised, registered memory-map decoder and transaction controller between the RV32I core's data port and its memory-mapped slaves (memory, timer, UART, GPIO and further peripherals). Instead of a fixed four-way combinational chip-select, it compares against a table of NUM_SLV base/mask regions, holds an active-low chip-select per slave for the whole access, and waits for a per-slave ready. It returns read data with an ack, or flags a bus error on an unmapped address or on slave timeout.

## Interface
- NUM_SLV, 4: number of slave regions (1..16).
- SLV_BASE, {32'hFFFF2000, 32'hFFFF1000, 32'hFFFF0000, 32'h00000000}: packed bases; slave i at bits [32i+31:32i].
- SLV_MASK, {32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFFE000}: packed masks; a 1 bit means that address bit is compared.
- TIMEOUT, 16: maximum ACCESS cycles waiting for ready; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  core request; held high until ack or err.
- we  in  1  1 selects a write, 0 selects a read.
- addr  in  32  byte address.
- slv_ready  in  NUM_SLV  per-slave access-complete flag.
- slv_rdata  in  32*NUM_SLV  packed per-slave read data.
- CS_N  out  NUM_SLV  registered active-low chip-selects.
- slv_we  out  1  registered copy of we, valid while any CS_N is low.
- rdata  out  32  captured read data.
- ack  out  1  one-cycle completion pulse.
- err  out  1  one-cycle bus-error pulse.
- busy  out  1  high in ACCESS and RESP.

## Operation
- Match rule: slave i hits when (addr & MASK_i) == (BASE_i & MASK_i). Overlapping regions resolve to the lowest index.
- State machine: IDLE, ACCESS, RESP.
- IDLE, req=1, hit: latch the slave index and we. Drive CS_N[idx] low and go to ACCESS.
- IDLE, req=1, miss: go to RESP with the error flag set. No CS_N is asserted.
- ACCESS: CS_N[idx] stays low. The timeout counter starts at 0 and increments each cycle.
- ACCESS, slv_ready[idx]=1: capture slv_rdata[idx] into rdata. On writes, rdata is left unchanged. Raise all CS_N and go to RESP with ack.
- ACCESS, counter reaches TIMEOUT-1 without ready: raise all CS_N and go to RESP with err.
- ACCESS, ready and timeout in the same cycle: ready wins.
- RESP: ack or err is high for exactly this cycle, then the FSM returns to IDLE.
- Ready bits of non-selected slaves are ignored.
- req dropping during ACCESS is ignored; the transaction completes.
- req is not sampled in RESP. A held req starts a new decode on the first IDLE cycle, giving back-to-back throughput of one access per 3 cycles minimum.
- Counter width is $clog2(TIMEOUT+1). With TIMEOUT=0 the counter is removed and ACCESS waits indefinitely.

## Timing
- Reset values: CS_N all 1, slv_we 0, rdata 0, ack 0, err 0, busy 0, state IDLE, counter 0.
- reset_n assertion mid-ACCESS raises CS_N asynchronously. No ack or err is produced.
- Hit with ready in the first ACCESS cycle:
  - req sampled at edge 0.
  - CS_N low during cycle 1.
  - ack and rdata valid during cycle 2.
- Minimum hit latency is 2 cycles from req to ack. Each cycle ready is late adds one cycle.
- Miss: err high in the cycle after req is sampled (1-cycle latency).
- Timeout with TIMEOUT=T: CS_N is low for exactly T cycles, and err follows in the next cycle.
- rdata holds its value until the next completed read.

## Configuration
- MMIO_FAULT_LOG_EN defined, extra registered outputs:
  - fault_addr [31:0]: address of the most recent err.
  - fault_is_to [0]: 1 for timeout, 0 for unmapped.
  - fault_cnt [7:0]: saturates at 255.
- Extra input fault_clr [0] zeroes all three fault outputs. If it coincides with an err, the new fault is recorded and fault_cnt is set to 1.
- All fault registers reset to 0.
- MMIO_FAULT_LOG_EN undefined: these ports and registers do not exist; behaviour is otherwise identical.

## Structure
- Package mmio_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - default base/mask constants for MEM, TC, UART and GPIO;
  - a localparam for the maximum NUM_SLV.
- Sub-module mmio_region_match: purely combinational address/table compare plus lowest-index priority encoder. Outputs hit and idx[$clog2(NUM_SLV)-1:0]. Instantiated once.

## Test plan
- Read 0x0000_0100, slave 0 ready in the first ACCESS cycle with rdata 0xDEADBEEF -> CS_N=4'b1110 for 1 cycle, ack at +2 cycles, rdata=0xDEADBEEF.
- Write 0xFFFF_2004, slave 3 ready after 3 cycles -> CS_N=4'b0111 for 4 cycles, slv_we=1, ack at +5 cycles, rdata unchanged.
- Read 0x1234_0000 (unmapped) -> no CS_N low, err at +1 cycle. With MMIO_FAULT_LOG_EN: fault_addr=0x12340000, fault_is_to=0, fault_cnt=1.
- Read 0xFFFF_1000, slave 2 never ready, TIMEOUT=16 -> CS_N[2] low 16 cycles, err on cycle 17, no ack. fault_is_to=1.
- Overlap: slave 1 reconfigured with base 0 and mask 0xFFFFF000, read 0x0000_0010 -> slave 0 selected. Then reset_n pulsed low during ACCESS -> CS_N all 1 immediately, no ack/err.
- Back-to-back: req held for two reads with immediate ready -> acks exactly 3 cycles apart.
